imem_fetch_responder: RTL and testbench

- Instruction-memory responder at the far end of the fetch interface driven by the PC/fetch initiator.
- Accepts word-addressed fetch requests over a valid/ready handshake and returns instructions in request order after a fixed pipeline latency.
- Responses pass through an internal buffer that absorbs back-pressure.
- Includes a write-only preload port for program images and a flush input for redirects.

---
 rtl/imem_fetch_responder.sv | 138 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word-addressed fetches return in order after a fixed
// latency through a small credit-managed response FIFO; includes a preload write port and flush.
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int RBUF = LATENCY + 1;
    localparam int PW   = $clog2(RBUF);
    localparam int CW   = $clog2(RBUF + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(RBUF - 1);

    logic          w_accept;
    logic          w_deliver;
    logic          w_req_err;
    logic          w_ld_ok;
    logic          w_fifo_wr;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_ld_idx;
    logic [CW-1:0] w_credit_used;
    logic [31:0]   w_fifo_instr;

    logic [31:0]              r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0][31:0] r_pd;
    logic [LATENCY-1:0]       r_pv;
    logic [LATENCY-1:0]       r_pe;
    logic [LATENCY-1:0][31:0] r_pa;

    logic [31:0]   r_fi [RBUF];
    logic [31:0]   r_fa [RBUF];
    logic          r_fe [RBUF];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_fcnt;
    logic [CW-1:0] r_outstanding;

    assign w_req_idx = req_addr[AW+1:2];
    assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign w_ld_idx  = ld_addr[AW+1:2];
    // The byte offset of a preload address carries no meaning; it is masked out here.
    assign w_ld_ok   = (ld_addr[31:AW+2] == '0) && ((ld_addr[1:0] & 2'b00) == 2'b00);

    assign w_deliver = rsp_valid && rsp_ready;
    assign w_accept  = req_valid && req_ready;

    // A response leaving this cycle frees its slot immediately, which keeps 1 req/cycle streaming.
    assign w_credit_used = r_outstanding - CW'(w_deliver);
    assign req_ready     = !rst && !flush && (w_credit_used < CW'(RBUF));

    // Memory and data pipeline carry no reset; validity is tracked by the control pipeline.
    always_ff @(posedge clk) begin
        if (ld_en && w_ld_ok) begin
            r_mem[w_ld_idx] <= ld_data;
        end
        if (w_accept) begin
            r_pd[0] <= r_mem[w_req_idx];
        end
        for (int j = 1; j < LATENCY; j++) begin
            r_pd[j] <= r_pd[j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            r_pe <= '0;
            r_pa <= '0;
        end else if (flush) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_accept;
            r_pa[0] <= req_addr;
            r_pe[0] <= w_req_err;
            for (int j = 1; j < LATENCY; j++) begin
                r_pv[j] <= r_pv[j-1];
                r_pa[j] <= r_pa[j-1];
                r_pe[j] <= r_pe[j-1];
            end
        end
    end

    assign w_fifo_wr    = r_pv[LATENCY-1];
    assign w_fifo_instr = r_pe[LATENCY-1] ? NOP_INSTR : r_pd[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RBUF; i++) begin
                r_fi[i] <= '0;
                r_fa[i] <= '0;
                r_fe[i] <= 1'b0;
            end
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_fcnt        <= '0;
            r_outstanding <= '0;
        end else if (flush) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_fcnt        <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_fi[r_wptr] <= w_fifo_instr;
                r_fa[r_wptr] <= r_pa[LATENCY-1];
                r_fe[r_wptr] <= r_pe[LATENCY-1];
                r_wptr       <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_deliver) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            r_fcnt        <= r_fcnt + CW'(w_fifo_wr) - CW'(w_deliver);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_deliver);
        end
    end

    assign rsp_valid = (r_fcnt != '0);
    assign rsp_instr = r_fi[r_rptr];
    assign rsp_addr  = r_fa[r_rptr];
    assign rsp_err   = r_fe[r_rptr];

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: expected responses are queued on acceptance
// and compared in order when the responder hands them over.
module tb_imem_fetch_responder;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_err  (rsp_err),
        .flush    (flush),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    int          lat_log[$];
    int          rsp_cyc_log[$];
    logic [31:0] last_instr;
    logic [31:0] last_addr;
    logic        last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop/compare on handshake, then drop on reset/flush, else push on acceptance.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got addr=%h instr=%h err=%0b, required no response",
                         rsp_addr, rsp_instr, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_addr !== e.addr || rsp_instr !== e.instr || rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp_data: got addr=%h instr=%h err=%0b, required addr=%h instr=%h err=%0b",
                             rsp_addr, rsp_instr, rsp_err, e.addr, e.instr, e.err);
                end else begin
                    $display("rsp addr=%h instr=%h err=%0b lat=%0d", rsp_addr, rsp_instr, rsp_err,
                             cyc - e.acc_cyc);
                end
                lat_log.push_back(cyc - e.acc_cyc);
            end
            n_rsp++;
            rsp_cyc_log.push_back(cyc);
            last_instr = rsp_instr;
            last_addr  = rsp_addr;
            last_err   = rsp_err;
        end
        if (rst || flush) begin
            sb.delete();
        end else if (req_valid && req_ready) begin
            n.addr    = req_addr;
            n.err     = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH);
            n.instr   = n.err ? NOP : model_mem[req_addr[11:2]];
            n.acc_cyc = cyc;
            sb.push_back(n);
        end
        if (ld_en && ld_addr[31:2] < DEPTH) begin
            model_mem[ld_addr[11:2]] = ld_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_cmp++;
        if (rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got instr=%h addr=%h err=%b required zeros", rsp_instr, rsp_addr, rsp_err);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", req_ready); end
        tick();
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 32'(4 * i); ld_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic test_stream();
        int base;
        int drops;
        base = n_rsp; drops = 0;
        lat_log.delete(); rsp_cyc_log.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            @(negedge clk);
            if (req_ready !== 1'b1) drops++;
            tick();
        end
        req_valid = 1'b0;
        wait_drain();
        n_cmp++;
        if (drops != 0) begin n_fail++; $display("FAIL stream_ready: got %0d drops required 0", drops); end
        n_cmp++;
        if (n_rsp - base != 8) begin n_fail++; $display("FAIL stream_count: got %0d required 8", n_rsp - base); end
        n_cmp++;
        if (lat_log.size() == 0 || lat_log[0] != LAT + 1) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d required %0d", (lat_log.size() == 0) ? -1 : lat_log[0], LAT + 1);
        end
        n_cmp++;
        if (rsp_cyc_log.size() != 8 || rsp_cyc_log[7] - rsp_cyc_log[0] != 7) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d responses not one per cycle, required 8 consecutive", rsp_cyc_log.size());
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int base;
        acc = 0;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_addr = 32'h10 + 32'(4 * i);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        base = n_rsp;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 32'h10 || rsp_instr !== 32'h1000_0004) begin
                n_fail++;
                $display("FAIL bp_hold: got ready=%b valid=%b addr=%h instr=%h required 0 1 00000010 10000004",
                         req_ready, rsp_valid, rsp_addr, rsp_instr);
            end
            tick();
        end
        n_cmp++;
        if (acc != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d required 3", acc); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b required 1", req_ready); end
        wait_drain();
        n_cmp++;
        if (n_rsp - base != 3) begin n_fail++; $display("FAIL bp_drain: got %0d required 3", n_rsp - base); end
    endtask

    task automatic test_error();
        int base;
        base = n_rsp;
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h2;
        tick();
        req_addr = 32'(DEPTH * 4);
        tick();
        req_valid = 1'b0;
        wait_drain();
        n_cmp++;
        if (n_rsp - base != 2) begin n_fail++; $display("FAIL err_count: got %0d required 2", n_rsp - base); end
        n_cmp++;
        if (last_err !== 1'b1 || last_instr !== NOP || last_addr !== 32'(DEPTH * 4)) begin
            n_fail++;
            $display("FAIL err_range: got err=%b instr=%h addr=%h required 1 %h %h", last_err, last_instr, last_addr, NOP, DEPTH * 4);
        end
    endtask

    task automatic test_flush();
        int base;
        base = n_rsp;
        tick();
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got ready=%b valid=%b required 0 0", req_ready, rsp_valid);
        end
        tick();
        flush = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (n_rsp - base != 1 || last_addr !== 32'h8 || last_instr !== 32'h1000_0002) begin
            n_fail++;
            $display("FAIL flush_after: got %0d rsp addr=%h instr=%h required 1 rsp 00000008 10000002",
                     n_rsp - base, last_addr, last_instr);
        end
    endtask

    task automatic test_rbw();
        tick();
        req_valid = 1'b1; req_addr = 32'hC;
        ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0; ld_en = 1'b0;
        wait_drain();
        n_cmp++;
        if (last_instr !== 32'h1000_0003) begin n_fail++; $display("FAIL rbw_old: got %h required 10000003", last_instr); end
        tick();
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_valid = 1'b0;
        wait_drain();
        n_cmp++;
        if (last_instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rbw_new: got %h required deadbeef", last_instr); end
    endtask

    task automatic test_reset_mid();
        int base;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            tick();
        end
        req_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b required 1", rsp_valid); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got valid=%b ready=%b required 0 0", rsp_valid, req_ready);
        end
        tick(); tick();
        rst = 1'b0; rsp_ready = 1'b1;
        base = n_rsp;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b required 1", req_ready); end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (n_rsp != base || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale: got %0d rsp valid=%b required 0 0", n_rsp - base, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_error();
        test_flush();
        test_rbw();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: got %0d left required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
